// File: rtl/ddr2_return_checker.sv
// Read-return consumer: pops the controller return path at a throttled rate, keeps a circular
// history of {data, address}, and optionally checks addresses advance by a fixed stride.
module ddr2_return_checker #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned ADX_W      = 27,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ADX_STRIDE = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       has_return_data,
  output logic                       get_return_data,
  input  logic [DATA_W-1:0]          return_data,
  input  logic [ADX_W-1:0]           return_adx,
  input  logic                       enable,
  input  logic [3:0]                 throttle,
  input  logic                       check_en,
  input  logic                       start,
  input  logic [ADX_W-1:0]           expect_base,
  input  logic [$clog2(DEPTH)-1:0]   buf_rd_idx,
  output logic [DATA_W-1:0]          buf_rd_data,
  output logic [ADX_W-1:0]           buf_rd_adx,
  output logic [$clog2(DEPTH):0]     buf_count,
  output logic [CNT_W-1:0]           word_count,
  output logic [CNT_W-1:0]           err_count,
  output logic                       err_flag,
  output logic [ADX_W-1:0]           last_err_adx
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StPop, StGap} state_e;

  state_e            state_q;
  logic [3:0]        gap_q;
  logic              get_q;
  logic              pop_d_q;
  logic [IdxW-1:0]   wr_ptr_q;
  logic [IdxW:0]     buf_count_q;
  logic [CNT_W-1:0]  word_count_q;
  logic [CNT_W-1:0]  err_count_q;
  logic              err_flag_q;
  logic [ADX_W-1:0]  last_err_adx_q;
  logic [ADX_W-1:0]  expected_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADX_W-1:0]  rd_adx_q;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADX_W-1:0]  mem_adx  [DEPTH];

  logic              pop_ok;
  logic              capture;
  logic              adx_mismatch;
  logic [IdxW-1:0]   rd_ptr;

  assign pop_ok       = has_return_data & enable & ~start;
  assign capture      = pop_d_q & ~start;
  assign adx_mismatch = check_en && (return_adx != expected_q);
  assign rd_ptr       = wr_ptr_q - IdxW'(1) - buf_rd_idx;

  // The last GAP cycle doubles as the idle sample slot, giving 1+max(throttle,1) pop spacing.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      gap_q   <= 4'd0;
      get_q   <= 1'b0;
    end else begin
      get_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop_ok) begin
            state_q <= StPop;
            get_q   <= 1'b1;
          end
        end
        StPop: begin
          state_q <= StGap;
          gap_q   <= (throttle == 4'd0) ? 4'd1 : throttle;
        end
        StGap: begin
          gap_q <= gap_q - 4'd1;
          if (gap_q <= 4'd1) begin
            if (pop_ok) begin
              state_q <= StPop;
              get_q   <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pop_d_q        <= 1'b0;
      wr_ptr_q       <= '0;
      buf_count_q    <= '0;
      word_count_q   <= '0;
      err_count_q    <= '0;
      err_flag_q     <= 1'b0;
      last_err_adx_q <= '0;
      expected_q     <= '0;
    end else begin
      pop_d_q <= get_q;
      if (start) begin
        wr_ptr_q       <= '0;
        buf_count_q    <= '0;
        word_count_q   <= '0;
        err_count_q    <= '0;
        err_flag_q     <= 1'b0;
        last_err_adx_q <= '0;
        expected_q     <= expect_base;
      end else if (pop_d_q) begin
        wr_ptr_q <= wr_ptr_q + IdxW'(1);
        if (buf_count_q != (IdxW+1)'(DEPTH)) buf_count_q <= buf_count_q + (IdxW+1)'(1);
        if (word_count_q != '1) word_count_q <= word_count_q + CNT_W'(1);
        if (adx_mismatch) begin
          if (err_count_q != '1) err_count_q <= err_count_q + CNT_W'(1);
          err_flag_q     <= 1'b1;
          last_err_adx_q <= return_adx;
        end
        // Resync to the observed address so a single gap costs one error.
        expected_q <= return_adx + ADX_W'(ADX_STRIDE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && capture) begin
      mem_data[wr_ptr_q] <= return_data;
      mem_adx[wr_ptr_q]  <= return_adx;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data_q <= '0;
      rd_adx_q  <= '0;
    end else begin
      rd_data_q <= mem_data[rd_ptr];
      rd_adx_q  <= mem_adx[rd_ptr];
    end
  end

  assign get_return_data = get_q;
  assign buf_rd_data     = rd_data_q;
  assign buf_rd_adx      = rd_adx_q;
  assign buf_count       = buf_count_q;
  assign word_count      = word_count_q;
  assign err_count       = err_count_q;
  assign err_flag        = err_flag_q;
  assign last_err_adx    = last_err_adx_q;

endmodule

// File: tb/tb_ddr2_return_checker.sv
// Bench for ddr2_return_checker: a return-path responder feeds queued words on each pop and a
// scoreboard checks each capture through history index 0, plus directed counter/boundary checks.
module tb_ddr2_return_checker;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADX_W  = 27;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADX_W-1:0]  adx;
  } ret_t;

  logic              clk = 1'b0;
  logic              resetn;
  logic              has_return_data = 1'b0;
  logic              get_return_data;
  logic [DATA_W-1:0] return_data = '0;
  logic [ADX_W-1:0]  return_adx = '0;
  logic              enable;
  logic [3:0]        throttle;
  logic              check_en;
  logic              start;
  logic [ADX_W-1:0]  expect_base;
  logic [2:0]        buf_rd_idx;
  logic [DATA_W-1:0] buf_rd_data;
  logic [ADX_W-1:0]  buf_rd_adx;
  logic [3:0]        buf_count;
  logic [CNT_W-1:0]  word_count;
  logic [CNT_W-1:0]  err_count;
  logic              err_flag;
  logic [ADX_W-1:0]  last_err_adx;

  ret_t        src_q[$];
  ret_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  bit          mon_en = 1'b0;
  logic [3:0]  hist = '0;
  int          first_pop, prev_pop, pops;

  always #5 clk = ~clk;

  ddr2_return_checker #(
    .DATA_W    (DATA_W),
    .ADX_W     (ADX_W),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W),
    .ADX_STRIDE(8)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .has_return_data(has_return_data),
    .get_return_data(get_return_data),
    .return_data    (return_data),
    .return_adx     (return_adx),
    .enable         (enable),
    .throttle       (throttle),
    .check_en       (check_en),
    .start          (start),
    .expect_base    (expect_base),
    .buf_rd_idx     (buf_rd_idx),
    .buf_rd_data    (buf_rd_data),
    .buf_rd_adx     (buf_rd_adx),
    .buf_count      (buf_count),
    .word_count     (word_count),
    .err_count      (err_count),
    .err_flag       (err_flag),
    .last_err_adx   (last_err_adx)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ret(input logic [DATA_W-1:0] d, input logic [ADX_W-1:0] a);
    src_q.push_back('{data: d, adx: a});
  endtask

  task automatic do_start(input logic [ADX_W-1:0] base);
    expect_base = base;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_get(input string tag);
    int i;
    i = 0;
    while (!get_return_data && i < 40) begin
      tick(1);
      i++;
    end
    chk(tag, get_return_data, 1'b1);
  endtask

  // Responder and scoreboard: a pop seen at sample k is driven now and read back at sample k+3.
  initial begin : responder
    ret_t ent;
    forever begin
      @(posedge clk);
      #1;
      hist = {hist[2:0], get_return_data};
      if (hist[3] && exp_q.size() != 0) begin
        ent = exp_q.pop_front();
        if (mon_en) begin
          chk("cap_data_idx0", buf_rd_data, ent.data);
          chk("cap_adx_idx0", buf_rd_adx, ent.adx);
        end
      end
      if (hist[0]) begin
        if (src_q.size() != 0) ent = src_q.pop_front();
        else ent = '0;
        return_data = ent.data;
        return_adx  = ent.adx;
        exp_q.push_back(ent);
      end
      has_return_data = (src_q.size() != 0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    resetn = 1'b0; enable = 1'b0; throttle = 4'd0; check_en = 1'b0;
    start = 1'b0; expect_base = '0; buf_rd_idx = '0;
    tick(4);
    chk("rst_get", get_return_data, 1'b0);
    chk("rst_word_count", word_count, 0);
    chk("rst_buf_count", buf_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_flag", err_flag, 1'b0);
    chk("rst_last_err", last_err_adx, 0);
    chk("rst_rd_data", buf_rd_data, 0);
    chk("rst_rd_adx", buf_rd_adx, 0);

    // Throttle 3: one pop every 4 cycles, 5 words.
    throttle = 4'd3; enable = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 5; i++) push_ret({$urandom, $urandom, $urandom, $urandom}, ADX_W'(i * 8));
    tick(2);
    resetn = 1'b1;
    first_pop = -1; prev_pop = -1; pops = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (get_return_data) begin
        if (first_pop < 0) first_pop = k;
        else chk("pop_spacing", k - prev_pop, 4);
        prev_pop = k;
        pops++;
      end
    end
    chk("first_pop_latency", first_pop >= 1 && first_pop <= 2, 1'b1);
    chk("pop_total", pops, 5);
    chk("t1_word_count", word_count, 5);
    chk("t1_buf_count", buf_count, 5);

    // In-sequence addresses from base 0x100.
    throttle = 4'd1; check_en = 1'b1;
    do_start(27'h100);
    push_ret({$urandom, $urandom, $urandom, $urandom}, 27'h100);
    push_ret({$urandom, $urandom, $urandom, $urandom}, 27'h108);
    push_ret({$urandom, $urandom, $urandom, $urandom}, 27'h110);
    tick(14);
    chk("seq_err_count", err_count, 0);
    chk("seq_err_flag", err_flag, 1'b0);
    chk("seq_word_count", word_count, 3);
    mon_en = 1'b0;
    buf_rd_idx = 3'd0; tick(1);
    chk("seq_idx0_adx", buf_rd_adx, 27'h110);
    buf_rd_idx = 3'd2; tick(1);
    chk("seq_idx2_adx", buf_rd_adx, 27'h100);
    buf_rd_idx = 3'd0; tick(1);
    mon_en = 1'b1;

    // One gap yields one error; flag is sticky.
    do_start(27'h100);
    push_ret({$urandom, $urandom, $urandom, $urandom}, 27'h100);
    push_ret({$urandom, $urandom, $urandom, $urandom}, 27'h118);
    push_ret({$urandom, $urandom, $urandom, $urandom}, 27'h120);
    push_ret({$urandom, $urandom, $urandom, $urandom}, 27'h128);
    push_ret({$urandom, $urandom, $urandom, $urandom}, 27'h130);
    tick(18);
    chk("gap_err_count", err_count, 1);
    chk("gap_last_err", last_err_adx, 27'h118);
    chk("gap_err_flag", err_flag, 1'b1);
    chk("gap_word_count", word_count, 5);

    // 11 captures wrap the 8-entry history; checking disabled.
    check_en = 1'b0;
    do_start(27'h0);
    for (int i = 0; i < 11; i++) push_ret(DATA_W'(i), ADX_W'(i * 16 + 4));
    tick(30);
    chk("wrap_buf_count", buf_count, 8);
    chk("wrap_word_count", word_count, 11);
    chk("wrap_no_check_err", err_count, 0);
    mon_en = 1'b0;
    buf_rd_idx = 3'd0; tick(1);
    chk("wrap_idx0_data", buf_rd_data, 10);
    buf_rd_idx = 3'd7; tick(1);
    chk("wrap_idx7_data", buf_rd_data, 3);
    buf_rd_idx = 3'd0; tick(1);
    mon_en = 1'b1;

    // Expected address wraps modulo 2^27.
    check_en = 1'b1;
    do_start(27'h7FFFFF8);
    push_ret(DATA_W'(128'hAA), 27'h7FFFFF8);
    push_ret(DATA_W'(128'hBB), 27'h0000000);
    tick(10);
    chk("adxwrap_err_count", err_count, 0);
    chk("adxwrap_word_count", word_count, 2);

    // start in the cycle a capture lands: that word is dropped, the next counts as 1.
    mon_en = 1'b0; check_en = 1'b0;
    do_start(27'h0);
    push_ret(DATA_W'(128'hA), 27'h0);
    push_ret(DATA_W'(128'hB), 27'h8);
    wait_get("start_pop_seen");
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_discard_wc", word_count, 0);
    chk("start_discard_bc", buf_count, 0);
    tick(8);
    chk("start_next_wc", word_count, 1);
    chk("start_next_data", buf_rd_data, 128'hB);

    // resetn low in the cycle a capture lands.
    check_en = 1'b1;
    do_start(27'h0);
    push_ret(DATA_W'(128'h1), 27'h40);
    push_ret(DATA_W'(128'h2), 27'h48);
    push_ret(DATA_W'(128'h3), 27'h50);
    wait_get("rst_pop1_seen");
    tick(1);
    wait_get("rst_pop2_seen");
    chk("pre_rst_err_flag", err_flag, 1'b1);
    tick(1);
    resetn = 1'b0;
    tick(1);
    chk("inrst_get", get_return_data, 1'b0);
    chk("inrst_word_count", word_count, 0);
    chk("inrst_buf_count", buf_count, 0);
    chk("inrst_err_count", err_count, 0);
    chk("inrst_err_flag", err_flag, 1'b0);
    chk("inrst_last_err", last_err_adx, 0);
    chk("inrst_rd_data", buf_rd_data, 0);
    chk("inrst_rd_adx", buf_rd_adx, 0);
    tick(1);
    chk("inrst_get_held", get_return_data, 1'b0);
    resetn = 1'b1;
    tick(6);
    chk("post_rst_word_count", word_count, 1);
    chk("post_rst_err_count", err_count, 1);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr2_return_checker.md
# ddr2_return_checker

Parametrised read-return consumer for the DDR2 memory-interface verification environment. It pops words from the controller's return path at a programmable rate and captures data and address into a circular history buffer. It optionally checks that return addresses arrive in sequence from a programmed base, and exposes word and error counters plus buffer readback for the bench and the logic-analyzer status path.

## Interface
Parameters:
- DATA_W, 128, return data width
- ADX_W, 27, return address width
- DEPTH, 8, capture buffer entries (power of 2, ≥2)
- CNT_W, 16, width of word/error counters
- ADX_STRIDE, 8, expected address increment per returned word

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- has_return_data  in  1  controller return path non-empty
- get_return_data  out  1  one-cycle pop pulse to controller
- return_data  in  DATA_W  return word, valid the cycle after a pop
- return_adx  in  ADX_W  return address, valid the cycle after a pop
- enable  in  1  allow pops; 0 stops new pops (in-flight capture completes)
- throttle  in  4  idle cycles enforced after each pop
- check_en  in  1  enable address-sequence checking
- start  in  1  pulse: clear counters/buffer, load expected address
- expect_base  in  ADX_W  expected first address, sampled on start
- buf_rd_idx  in  log2(DEPTH)  history index, 0 = most recent capture
- buf_rd_data  out  DATA_W  captured data at buf_rd_idx
- buf_rd_adx  out  ADX_W  captured address at buf_rd_idx
- buf_count  out  log2(DEPTH)+1  valid entries, saturates at DEPTH
- word_count  out  CNT_W  captured words, saturating
- err_count  out  CNT_W  address mismatches, saturating
- err_flag  out  1  sticky mismatch indicator
- last_err_adx  out  ADX_W  address of most recent mismatching word

## Operation
- Pop FSM, states IDLE, POP, GAP:
  - IDLE -> POP when has_return_data & enable & !start.
  - POP: get_return_data=1 for exactly this cycle; -> GAP with gap counter = max(throttle,1).
  - GAP decrements each cycle; -> IDLE at 0.
  - get_return_data is never high two consecutive cycles; throttle is sampled on entry to GAP.
- Capture: pop_d (registered get_return_data) marks the data cycle; on that edge write {return_data, return_adx} at wr_ptr, wr_ptr++ (wraps mod DEPTH, overwriting oldest), buf_count++ saturating at DEPTH, word_count++ saturating at 2^CNT_W-1.
- Check, when check_en on a capture: compare return_adx to expected. On mismatch: err_count++ (saturating), err_flag<=1, last_err_adx<=return_adx. In all cases expected <= return_adx + ADX_STRIDE, mod 2^ADX_W. Resync means one gap yields one error. When check_en=0, expected still tracks.
- Readback entry = (wr_ptr-1-buf_rd_idx) mod DEPTH. Indices ≥ buf_count return stale/zero contents, undefined for checking.
- start (one cycle): word_count, err_count, err_flag, last_err_adx, buf_count, wr_ptr <= 0; expected <= expect_base. A capture on the same edge as start is discarded. A pop in FSM POP completes, but its data is still captured the next cycle (counted after the clear). Buffer RAM is not cleared.
- Reset (resetn=0, any state): FSM IDLE, gap counter 0, get_return_data 0, pop_d 0, all counters/flags/pointers 0, expected 0, buf_rd_data 0, buf_rd_adx 0. In-flight data is discarded.

## Timing
- Pop at cycle T; data sampled at end of T+1; word_count/err_count/err_flag/buf_count updated visible T+2.
- Min pop spacing = 1+max(throttle,1) cycles; throttle=0 and 1 both give one pop per 2 cycles; throttle=15 gives one per 16.
- has_return_data must be sampled high in IDLE; pop issues the cycle after, registered.
- buf_rd_data/buf_rd_adx registered: one-cycle latency from buf_rd_idx; a capture at edge E is readable at idx 0 on output after E+1.
- enable falling during GAP: no further pops. Rising: pop earliest next IDLE cycle.

## Test plan
- Reset, has_return_data=1, enable=1, throttle=3: first get pulse 2 cycles after reset release, then every 4 cycles; after 5 pops word_count=5, buf_count=5.
- start with expect_base=0x100, check_en=1, returns 0x100,0x108,0x110 -> err_count=0, err_flag=0; idx0 reads 0x110, idx2 reads 0x100.
- Returns 0x100,0x118,0x120 -> err_count=1, last_err_adx=0x118, err_flag stays 1 after further correct words.
- DEPTH=8, 11 captures with data=i -> buf_count=8, idx0 data=10, idx7 data=3.
- expect_base=0x7FFFFF8 (27-bit), returns 0x7FFFFF8 then 0x0000000 -> no error (wrap).
- Assert start in the cycle a capture lands, and separately resetn=0 in that cycle: start -> word_count=0, next pop counted as 1. Reset -> all outputs 0, get_return_data low while resetn low.
